// File: rtl/dat_mem_stack.sv
`default_nettype none
// ============================================================================
// Module      : dat_mem_stack
// Description : DEPTH x W single-write-port memory with combinational reads.
//               Its top STK_DEPTH words hold a downward-growing stack.
//               When the INIT_TABLE_EN macro is defined, a short init
//               sequencer runs after reset and loads a constant table into
//               addresses 60..74. When the macro is undefined, reset goes
//               straight to normal operation and busy is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module dat_mem_stack #(
  parameter int W         = 8,
  parameter int AW        = 8,
  parameter int STK_DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  dat_in,
  input  logic          wr_en,
  input  logic [AW-1:0] addr,
  input  logic          push,
  input  logic          pop,
  output logic [W-1:0]  dat_out,
  output logic [W-1:0]  top,
  output logic [AW-1:0] sp,
  output logic          empty,
  output logic          full,
  output logic          busy
);

  localparam int              DEPTH      = 2**AW;
  localparam logic [AW-1:0]   C_SP_EMPTY = AW'(DEPTH - 1);
  localparam logic [AW-1:0]   C_SP_FULL  = AW'(DEPTH - 1 - STK_DEPTH);

  logic [W-1:0]  r_core [DEPTH];
  logic [AW-1:0] r_sp;

  logic          w_we;
  logic          w_we_go;
  logic [AW-1:0] w_waddr;
  logic [W-1:0]  w_wdata;
  logic [AW-1:0] w_sp_nxt;

`ifdef INIT_TABLE_EN
  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [AW-1:0] C_TBL_BASE = AW'(60);
  localparam logic [3:0]    C_TBL_LAST = 4'd14;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_idx;
  logic [3:0] w_idx_nxt;

  // Constant table image for addresses 60..74 (8-bit source, resized to W).
  function automatic logic [W-1:0] tbl_word(input logic [3:0] i);
    logic [7:0] v;
    case (i)
      4'd0:    v = 8'h10;
      4'd1:    v = 8'hE0;
      4'd2:    v = 8'hF0;
      4'd3:    v = 8'hCC;
      4'd4:    v = 8'hAA;
      4'd5:    v = 8'h1E;
      4'd6:    v = 8'h80;
      4'd7:    v = 8'h10;
      4'd8:    v = 8'h00;
      4'd9:    v = 8'h7F;
      4'd10:   v = 8'h08;
      4'd11:   v = 8'h40;
      4'd12:   v = 8'hF8;
      4'd13:   v = 8'h01;
      4'd14:   v = 8'h08;
      default: v = 8'h00;
    endcase
    return W'(v);
  endfunction

  // Sequencer state and table index register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_INIT;
      r_idx   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Sequencer next state: step through the table once, then hand over.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    if (r_state == S_INIT) begin
      w_idx_nxt = r_idx + 4'd1;
      if (r_idx == C_TBL_LAST) begin
        w_state_nxt = S_RUN;
        w_idx_nxt   = 4'd0;
      end
    end
  end

  assign busy = (r_state == S_INIT);
`else
  assign busy = 1'b0;
`endif

  assign empty = (r_sp == C_SP_EMPTY);
  assign full  = (r_sp == C_SP_FULL);

  // Write-port arbitration: init sequencer, then stack ops, then random write.
  always_comb begin
    w_we     = 1'b0;
    w_waddr  = addr;
    w_wdata  = dat_in;
    w_sp_nxt = r_sp;
`ifdef INIT_TABLE_EN
    if (r_state == S_INIT) begin
      w_we    = 1'b1;
      w_waddr = C_TBL_BASE + AW'(r_idx);
      w_wdata = tbl_word(r_idx);
    end else
`endif
    if (push && pop && !empty) begin
      // Replace the top word in place.
      w_we    = 1'b1;
      w_waddr = r_sp + AW'(1);
    end else if (push && !full) begin
      // Plain push, also taken by push+pop on an empty stack.
      w_we     = 1'b1;
      w_waddr  = r_sp;
      w_sp_nxt = r_sp - AW'(1);
    end else if (pop && !push && !empty) begin
      w_sp_nxt = r_sp + AW'(1);
    end else if (wr_en && !push && !pop) begin
      w_we = 1'b1;
    end
  end

  // Writes are held off while reset is asserted so memory outside the table keeps its contents.
  assign w_we_go = w_we & rst_n;

  // Stack pointer register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sp <= C_SP_EMPTY;
    end else begin
      r_sp <= w_sp_nxt;
    end
  end

  // Memory array write port; there is no reset.
  always_ff @(posedge clk) begin
    if (w_we_go) begin
      r_core[w_waddr] <= w_wdata;
    end
  end

  assign dat_out = r_core[addr];
  assign top     = empty ? '0 : r_core[r_sp + AW'(1)];
  assign sp      = r_sp;

endmodule
`default_nettype wire
